// File: rtl/pe_stage_sched.sv
// Time-shares one 8-bit add/sub PE across the f/g pair operations of an SC-decoder stage.
// Each pair takes READ -> EXEC -> WRITE (three cycles). Results are saturated to the LLR range.
module pe_stage_sched #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int PW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [PW:0]       len,
  input  logic [AW-1:0]     rd_base,
  input  logic [AW-1:0]     wr_base,
  input  logic [2**PW-1:0]  ps,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr_a,
  output logic [AW-1:0]     rd_addr_b,
  input  logic [DW-1:0]     rd_data_a,
  input  logic [DW-1:0]     rd_data_b,
  output logic [DW-1:0]     pe_x,
  output logic [DW-1:0]     pe_y,
  input  logic [DW-1:0]     pe_s,
  input  logic [DW-1:0]     pe_d,
  input  logic              pe_bout,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [PW:0]   IDX_ONE = 1;

  logic [2:0]        state_reg;
  logic [PW:0]       idx_reg;
  logic [PW:0]       idx_next;
  logic              op_reg;
  logic [PW:0]       len_reg;
  logic [AW-1:0]     rd_base_reg;
  logic [AW-1:0]     wr_base_reg;
  logic [2**PW-1:0]  ps_reg;
  logic [DW-1:0]     pe_x_reg;
  logic [DW-1:0]     pe_y_reg;
  logic [DW-1:0]     wr_data_reg;

  logic [DW-1:0]     abs_a;
  logic [DW-1:0]     abs_b;
  logic [DW-1:0]     min_mag;
  logic              u_bit;
  logic              sum_ovf;
  logic              diff_ovf;
  logic [DW-1:0]     result_next;

  // |-128| has no positive representation, so it folds to +127.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
    if (v == SAT_NEG)
      return SAT_POS;
    else if (v[DW-1])
      return -v;
    else
      return v;
  endfunction

  assign rd_en     = (state_reg == S_READ);
  assign wr_en     = (state_reg == S_WRITE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign rd_addr_a = rd_base_reg + AW'(idx_reg);
  assign rd_addr_b = rd_base_reg + AW'(len_reg) + AW'(idx_reg);
  assign wr_addr   = wr_base_reg + AW'(idx_reg);
  assign wr_data   = wr_data_reg;
  assign idx_next  = idx_reg + IDX_ONE;

  always_comb begin
    abs_a       = abs_sat(rd_data_a);
    abs_b       = abs_sat(rd_data_b);
    u_bit       = ps_reg[idx_reg[PW-1:0]];
    pe_x        = pe_x_reg;
    pe_y        = pe_y_reg;
    min_mag     = pe_bout ? abs_a : abs_b;
    sum_ovf     = (rd_data_a[DW-1] == rd_data_b[DW-1]) && (pe_s[DW-1] != rd_data_a[DW-1]);
    diff_ovf    = (rd_data_b[DW-1] != rd_data_a[DW-1]) && (pe_d[DW-1] != rd_data_b[DW-1]);
    result_next = pe_s;
    // The PE is only driven with fresh operands in EXEC; otherwise it sees the previous pair.
    if (state_reg == S_EXEC) begin
      pe_x = op_reg ? rd_data_b : abs_a;
      pe_y = op_reg ? rd_data_a : abs_b;
    end
    if (!op_reg) begin
      result_next = (rd_data_a[DW-1] ^ rd_data_b[DW-1]) ? -min_mag : min_mag;
    end else if (!u_bit) begin
      result_next = sum_ovf ? (rd_data_a[DW-1] ? SAT_NEG : SAT_POS) : pe_s;
    end else begin
      result_next = diff_ovf ? (rd_data_b[DW-1] ? SAT_NEG : SAT_POS) : pe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      op_reg      <= 1'b0;
      len_reg     <= '0;
      rd_base_reg <= '0;
      wr_base_reg <= '0;
      ps_reg      <= '0;
      pe_x_reg    <= '0;
      pe_y_reg    <= '0;
      wr_data_reg <= '0;
    end else begin
      pe_x_reg <= pe_x;
      pe_y_reg <= pe_y;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg      <= op;
            len_reg     <= len;
            rd_base_reg <= rd_base;
            wr_base_reg <= wr_base;
            ps_reg      <= ps;
            idx_reg     <= '0;
            state_reg   <= (len == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: state_reg <= S_EXEC;
        S_EXEC: begin
          wr_data_reg <= result_next;
          state_reg   <= S_WRITE;
        end
        S_WRITE: begin
          if (idx_next == len_reg) begin
            state_reg <= S_DONE;
          end else begin
            idx_reg   <= idx_next;
            state_reg <= S_READ;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stage_sched.sv
// Directed bench for pe_stage_sched with a behavioural PE and LLR RAM around it.
// Each task drives one scenario and compares against hand-computed results.
module tb_pe_stage_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [5:0]  len = '0;
  logic [7:0]  rd_base = '0;
  logic [7:0]  wr_base = '0;
  logic [31:0] ps = '0;
  logic        rd_en;
  logic [7:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a = '0, rd_data_b = '0;
  logic [7:0]  pe_x, pe_y, pe_s, pe_d;
  logic        pe_bout;
  logic        wr_en;
  logic [7:0]  wr_addr, wr_data;
  logic        busy, done;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];
  int         wq_cyc[$];
  logic [7:0] rq_a[$];
  logic [7:0] rq_b[$];
  int         dq[$];
  int         busy_cnt, busy_first, busy_last, both_cnt;

  pe_stage_sched #(.DW(8), .AW(8), .PW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len),
    .rd_base(rd_base), .wr_base(wr_base), .ps(ps),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pe_x(pe_x), .pe_y(pe_y), .pe_s(pe_s), .pe_d(pe_d), .pe_bout(pe_bout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pe_s    = pe_x + pe_y;
  assign pe_d    = pe_x - pe_y;
  assign pe_bout = (pe_x < pe_y);

  always @(posedge clk)
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(rel);
    end
    if (rd_en) begin
      rq_a.push_back(rd_addr_a);
      rq_b.push_back(rd_addr_b);
    end
    if (done) dq.push_back(rel);
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (rd_en && wr_en) both_cnt++;
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    rq_a.delete(); rq_b.delete(); dq.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1; both_cnt = 0;
  endtask

  // Start is driven in cycle 0; afterwards every job input is scrambled to prove it was latched.
  task automatic go(input logic o, input logic [5:0] l, input logic [7:0] rb, input logic [7:0] wb,
                    input logic [31:0] p);
    @(posedge clk); #1;
    clear_mon();
    t0 = cyc;
    start = 1'b1; op = o; len = l; rd_base = rb; wr_base = wb; ps = p;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; len = 6'd7; rd_base = rb + 8'd3; wr_base = wb + 8'd5; ps = ~p;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && dq.size() == 0; k++) @(negedge clk);
    nchk++;
    if (dq.size() == 0) begin
      nerr++;
      $display("FAIL done_timeout: got no done pulse, required one within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nchk++;
    if ({rd_en, wr_en, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_strobes: got %b required 0000", {rd_en, wr_en, busy, done});
    end
    nchk++;
    if ({rd_addr_a, rd_addr_b, wr_addr, wr_data, pe_x, pe_y} !== 48'h0) begin
      nerr++;
      $display("FAIL reset_values: got %h required 0", {rd_addr_a, rd_addr_b, wr_addr, wr_data, pe_x, pe_y});
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_f_basic();
    logic [7:0] exp_d [0:1] = '{8'hF9, 8'h32};
    mem[8'h04] = 8'd20; mem[8'h05] = 8'h9C; mem[8'h06] = 8'hF9; mem[8'h07] = 8'hCE;
    go(1'b0, 6'd2, 8'h04, 8'h80, 32'h0);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (wq_data.size() != 2) begin
      nerr++; $display("FAIL f_basic_count: got %0d writes required 2", wq_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (wq_data[i] !== exp_d[i] || wq_addr[i] !== 8'h80 + 8'(i) || wq_cyc[i] != 3*i+3) begin
          nerr++;
          $display("FAIL f_basic_wr%0d: got data %h addr %h cyc %0d required %h %h %0d",
                   i, wq_data[i], wq_addr[i], wq_cyc[i], exp_d[i], 8'h80 + 8'(i), 3*i+3);
        end
        $display("f_basic pair %0d: wr %h -> %h", i, wq_addr[i], wq_data[i]);
      end
    end
    nchk++;
    if (dq.size() != 1 || dq[0] != 7 || busy_cnt != 7 || busy_first != 1 || busy_last != 7) begin
      nerr++;
      $display("FAIL f_basic_timing: got done %0d busy cnt %0d %0d..%0d required done 7 busy 7 1..7",
               dq.size() ? dq[0] : -1, busy_cnt, busy_first, busy_last);
    end
  endtask

  task automatic test_g_sat();
    logic [7:0] exp_d [0:1] = '{8'h7F, 8'h80};
    mem[8'h20] = 8'd100; mem[8'h21] = 8'd5; mem[8'h22] = 8'd60; mem[8'h23] = 8'h80;
    go(1'b1, 6'd2, 8'h20, 8'h90, 32'b10);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (wq_data.size() != 2) begin
      nerr++; $display("FAIL g_sat_count: got %0d writes required 2", wq_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (wq_data[i] !== exp_d[i] || wq_addr[i] !== 8'h90 + 8'(i)) begin
          nerr++;
          $display("FAIL g_sat_wr%0d: got %h at %h required %h at %h", i, wq_data[i], wq_addr[i],
                   exp_d[i], 8'h90 + 8'(i));
        end
        $display("g_sat pair %0d: wr %h -> %h", i, wq_addr[i], wq_data[i]);
      end
    end
  endtask

  task automatic test_g_plain_wrap();
    logic [7:0] exp_d [0:1] = '{8'h0A, 8'hE7};
    mem[8'hFE] = 8'd10; mem[8'hFF] = 8'hE2; mem[8'h00] = 8'd20; mem[8'h01] = 8'd5;
    go(1'b1, 6'd2, 8'hFE, 8'hA8, 32'b01);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (rq_b.size() != 2 || rq_b[0] !== 8'h00 || rq_b[1] !== 8'h01 || rq_a[1] !== 8'hFF) begin
      nerr++; $display("FAIL g_wrap_rdaddr: got %0d reads, b addresses not 00,01 or a[1] not ff", rq_b.size());
    end
    nchk++;
    if (wq_data.size() != 2) begin
      nerr++; $display("FAIL g_plain_count: got %0d writes required 2", wq_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (wq_data[i] !== exp_d[i]) begin
          nerr++; $display("FAIL g_plain_wr%0d: got %h required %h", i, wq_data[i], exp_d[i]);
        end
        $display("g_plain pair %0d: wr %h -> %h", i, wq_addr[i], wq_data[i]);
      end
    end
  endtask

  task automatic test_f_edge();
    logic [7:0] exp_d [0:2] = '{8'hFD, 8'h7F, 8'hF7};
    mem[8'h30] = 8'h80; mem[8'h31] = 8'h80; mem[8'h32] = 8'h09;
    mem[8'h33] = 8'h03; mem[8'h34] = 8'h80; mem[8'h35] = 8'hF7;
    go(1'b0, 6'd3, 8'h30, 8'hA0, 32'h0);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (wq_data.size() != 3) begin
      nerr++; $display("FAIL f_edge_count: got %0d writes required 3", wq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (wq_data[i] !== exp_d[i]) begin
          nerr++; $display("FAIL f_edge_wr%0d: got %h required %h", i, wq_data[i], exp_d[i]);
        end
        $display("f_edge pair %0d: wr %h -> %h", i, wq_addr[i], wq_data[i]);
      end
    end
  endtask

  task automatic test_timing_ignore_start();
    logic [7:0] exp_d [0:3] = '{8'h01, 8'hFE, 8'hFD, 8'h04};
    mem[8'h10] = 8'h01; mem[8'h11] = 8'hFE; mem[8'h12] = 8'h03; mem[8'h13] = 8'hFC;
    mem[8'h14] = 8'h05; mem[8'h15] = 8'h06; mem[8'h16] = 8'hF9; mem[8'h17] = 8'hF8;
    go(1'b0, 6'd4, 8'h10, 8'h40, 32'h0);
    while (cyc - t0 < 5) begin @(posedge clk); #1; end
    start = 1'b1; len = 6'd1; op = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    repeat (3) @(negedge clk);
    nchk++;
    if (wq_data.size() != 4 || rq_a.size() != 4) begin
      nerr++; $display("FAIL len4_count: got %0d writes %0d reads required 4 4", wq_data.size(), rq_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (wq_data[i] !== exp_d[i] || wq_addr[i] !== 8'h40 + 8'(i) || wq_cyc[i] != 3*i+3 ||
            rq_a[i] !== 8'h10 + 8'(i) || rq_b[i] !== 8'h14 + 8'(i)) begin
          nerr++;
          $display("FAIL len4_wr%0d: got data %h addr %h cyc %0d ra %h rb %h required %h %h %0d %h %h",
                   i, wq_data[i], wq_addr[i], wq_cyc[i], rq_a[i], rq_b[i],
                   exp_d[i], 8'h40 + 8'(i), 3*i+3, 8'h10 + 8'(i), 8'h14 + 8'(i));
        end
        $display("len4 pair %0d: wr %h -> %h at cycle %0d", i, wq_addr[i], wq_data[i], wq_cyc[i]);
      end
    end
    nchk++;
    if (dq.size() != 1 || dq[0] != 13 || both_cnt != 0) begin
      nerr++;
      $display("FAIL len4_done: got %0d pulses first at %0d overlap %0d required 1 at 13 overlap 0",
               dq.size(), dq.size() ? dq[0] : -1, both_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] exp_d [0:1] = '{8'hF9, 8'h32};
    for (int i = 0; i < 16; i++) mem[8'h50 + 8'(i)] = 8'(i + 1);
    go(1'b0, 6'd8, 8'h50, 8'hC0, 32'h0);
    for (int k = 0; k < 40 && wq_data.size() < 2; k++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    nchk++;
    if ({busy, rd_en, wr_en, done} !== 4'b0000 || wr_data !== 8'h00 || rd_addr_a !== 8'h00 || pe_x !== 8'h00) begin
      nerr++;
      $display("FAIL rst_mid_outputs: got busy/rd/wr/done %b wr_data %h rd_addr_a %h pe_x %h required 0",
               {busy, rd_en, wr_en, done}, wr_data, rd_addr_a, pe_x);
    end
    repeat (30) @(negedge clk);
    nchk++;
    if (wq_data.size() != 2 || dq.size() != 0) begin
      nerr++; $display("FAIL rst_mid_quiet: got %0d writes %0d done required 2 0", wq_data.size(), dq.size());
    end
    $display("rst_mid: %0d writes before reset, %0d done pulses", wq_data.size(), dq.size());
    go(1'b0, 6'd2, 8'h04, 8'hE0, 32'h0);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (wq_data.size() != 2 || dq[0] != 7 || wq_data[0] !== exp_d[0] || wq_data[1] !== exp_d[1] ||
        wq_addr[1] !== 8'hE1) begin
      nerr++;
      $display("FAIL rst_fresh_job: got %0d writes, done at %0d, first data %h required 2, 7, f9",
               wq_data.size(), dq.size() ? dq[0] : -1, wq_data.size() ? wq_data[0] : 8'hxx);
    end
    $display("rst_fresh: %0d writes, done at %0d", wq_data.size(), dq.size() ? dq[0] : -1);
  endtask

  task automatic test_back_to_back();
    mem[8'h70] = 8'hEC; mem[8'h71] = 8'h0F;
    go(1'b0, 6'd0, 8'h60, 8'h20, 32'h0);
    wait_done(10);
    nchk++;
    if (dq.size() != 1 || dq[0] != 1 || busy_cnt != 1 || busy_first != 1 || rq_a.size() != 0 ||
        wq_data.size() != 0) begin
      nerr++;
      $display("FAIL len0: got done %0d busy cnt %0d first %0d reads %0d writes %0d required 1 1 1 0 0",
               dq.size() ? dq[0] : -1, busy_cnt, busy_first, rq_a.size(), wq_data.size());
    end
    $display("len0: done at cycle %0d", dq.size() ? dq[0] : -1);
    go(1'b0, 6'd1, 8'h70, 8'h30, 32'h0);
    wait_done(20);
    repeat (3) @(negedge clk);
    nchk++;
    if (dq[0] != 4 || busy_cnt != 4 || busy_first != 1 || wq_data.size() != 1 ||
        wq_data[0] !== 8'hF1 || wq_addr[0] !== 8'h30) begin
      nerr++;
      $display("FAIL back_to_back: got done %0d busy %0d from %0d writes %0d required 4 4 1 1 (f1 at 30)",
               dq.size() ? dq[0] : -1, busy_cnt, busy_first, wq_data.size());
    end
    $display("back_to_back: done at %0d, %0d writes", dq.size() ? dq[0] : -1, wq_data.size());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_mon();
    test_reset();
    test_f_basic();
    test_g_sat();
    test_g_plain_wrap();
    test_f_edge();
    test_timing_ignore_start();
    test_reset_mid_job();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
